// File: rtl/rr_grant_arbiter_4_if.sv
// Request/grant bundle between four requesters and the round-robin arbiter.
// The master side drives req/done; the arbiter (slave) returns a registered one-hot grant.
interface rr_grant_arbiter_4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic       grant_valid;
  logic       timeout;

  modport master (output req, done, input grant, grant_valid, timeout);
  modport slave  (input req, done, output grant, grant_valid, timeout);
endinterface

// File: rtl/rr_grant_arbiter_4.sv
// Four-channel round-robin arbiter with registered one-hot grant; 1-cycle req-to-grant latency.
// No backpressure: a grant is held until done, owner req drop, or watchdog; one idle cycle follows each grant.
module rr_grant_arbiter_4 #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  rr_grant_arbiter_4_if.slave arb
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_LAST);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

  state_t           state;
  logic [1:0]       last;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       grant_q;
  logic             grant_valid_q;
  logic             timeout_q;

  logic [1:0]       cand;
  logic [1:0]       pick_idx;
  logic             pick_vld;
  logic             owner_rel;
  logic             wd_fire;
  logic             rel;

  // Scan from the farthest candidate to the nearest so the nearest set bit wins.
  always_comb begin
    cand     = last;
    pick_idx = last;
    pick_vld = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (arb.req[cand]) begin
        pick_idx = cand;
        pick_vld = 1'b1;
      end
    end
  end

  // In GRANT, last holds the owner's index.
  assign owner_rel = arb.done | ~arb.req[last];
  assign wd_fire   = (TIMEOUT != 0) && (cnt == CNT_LAST);
  assign rel       = owner_rel | wd_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last          <= 2'd3;
      cnt           <= '0;
      grant_q       <= 4'b0000;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant_q       <= 4'b0001 << pick_idx;
            grant_valid_q <= 1'b1;
            last          <= pick_idx;
            cnt           <= '0;
            state         <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            grant_q       <= 4'b0000;
            grant_valid_q <= 1'b0;
            state         <= IDLE;
            // A coincident done or request drop counts as a normal release.
            timeout_q     <= wd_fire & ~owner_rel;
          end else if (cnt != CNT_SAT) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign arb.grant       = grant_q;
  assign arb.grant_valid = grant_valid_q;
  assign arb.timeout     = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter_4.sv
// Directed bench for rr_grant_arbiter_4 (TIMEOUT=4): vector table plus hand sequences for watchdog and reset.
module tb_rr_grant_arbiter_4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  rr_grant_arbiter_4_if bus ();

  rr_grant_arbiter_4 #(.TIMEOUT(4), .CNT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .arb   (bus)
  );

  typedef struct packed {
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic       to;
  } vec_t;

  vec_t vq[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [3:0] g, input logic to);
    chk({name, ".grant"}, bus.grant, g);
    chk({name, ".grant_valid"}, bus.grant_valid, g != 4'b0000);
    chk({name, ".timeout"}, bus.timeout, to);
  endtask

  // Grant must be zero- or one-hot and grant_valid must agree with it on every cycle.
  always @(negedge clk) begin
    chk("onehot", ($countones(bus.grant) <= 1), 1'b1);
    chk("gv_track", bus.grant_valid, bus.grant != 4'b0000);
  end

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    bus.req  = 4'b0000;
    bus.done = 1'b0;

    // {req, done, expected grant, expected timeout}, outputs checked after the edge
    vq.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0});
    vq.push_back('{4'b0001, 1'b0, 4'b0001, 1'b0});
    vq.push_back('{4'b0001, 1'b0, 4'b0001, 1'b0});
    vq.push_back('{4'b0001, 1'b0, 4'b0001, 1'b0});
    vq.push_back('{4'b0001, 1'b1, 4'b0000, 1'b0});
    vq.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0});
    // rotation with last=0
    vq.push_back('{4'b1111, 1'b0, 4'b0010, 1'b0});
    vq.push_back('{4'b1111, 1'b1, 4'b0000, 1'b0});
    vq.push_back('{4'b1111, 1'b0, 4'b0100, 1'b0});
    vq.push_back('{4'b1111, 1'b1, 4'b0000, 1'b0});
    vq.push_back('{4'b1111, 1'b0, 4'b1000, 1'b0});
    vq.push_back('{4'b1111, 1'b1, 4'b0000, 1'b0});
    vq.push_back('{4'b1111, 1'b0, 4'b0001, 1'b0});
    vq.push_back('{4'b1111, 1'b1, 4'b0000, 1'b0});
    vq.push_back('{4'b1111, 1'b0, 4'b0010, 1'b0});
    vq.push_back('{4'b1111, 1'b1, 4'b0000, 1'b0});
    // serve channel 0, then skip empty channels 1 and 2
    vq.push_back('{4'b0001, 1'b0, 4'b0001, 1'b0});
    vq.push_back('{4'b0001, 1'b1, 4'b0000, 1'b0});
    vq.push_back('{4'b1001, 1'b0, 4'b1000, 1'b0});
    vq.push_back('{4'b1001, 1'b1, 4'b0000, 1'b0});
    vq.push_back('{4'b1001, 1'b0, 4'b0001, 1'b0});
    vq.push_back('{4'b1001, 1'b1, 4'b0000, 1'b0});
    // non-owner request churn during a grant, then done in idle
    vq.push_back('{4'b0010, 1'b0, 4'b0010, 1'b0});
    vq.push_back('{4'b1110, 1'b0, 4'b0010, 1'b0});
    vq.push_back('{4'b0110, 1'b0, 4'b0010, 1'b0});
    vq.push_back('{4'b0010, 1'b1, 4'b0000, 1'b0});
    vq.push_back('{4'b0000, 1'b1, 4'b0000, 1'b0});
    vq.push_back('{4'b0000, 1'b0, 4'b0000, 1'b0});

    step();
    chk_out("reset", 4'b0000, 1'b0);
    #5;
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      bus.req  = vq[i].req;
      bus.done = vq[i].done;
      step();
      chk_out($sformatf("vec%0d", i), vq[i].grant, vq[i].to);
    end

    // Watchdog: last=1, channel 1 alone holds for 4 cycles then is force-released.
    bus.req  = 4'b0010;
    bus.done = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_out($sformatf("wd_hold%0d", c), 4'b0010, 1'b0);
    end
    step();
    chk_out("wd_release", 4'b0000, 1'b1);
    step();
    chk_out("wd_regrant", 4'b0010, 1'b0);

    // Release race: done in the 4th grant cycle is a normal release.
    step();
    step();
    step();
    chk_out("race_4th", 4'b0010, 1'b0);
    bus.done = 1'b1;
    step();
    chk_out("race_release", 4'b0000, 1'b0);
    bus.done = 1'b0;
    bus.req  = 4'b0000;
    step();
    chk_out("race_idle", 4'b0000, 1'b0);

    // Owner drop: channel 2 granted then drops its request.
    bus.req = 4'b0100;
    step();
    chk_out("drop_grant", 4'b0100, 1'b0);
    step();
    bus.req = 4'b0000;
    step();
    chk_out("drop_release", 4'b0000, 1'b0);
    step();
    chk_out("drop_idle", 4'b0000, 1'b0);

    // Asynchronous reset mid-grant, then channel 0 wins first.
    bus.req = 4'b0100;
    step();
    chk_out("rst_pre", 4'b0100, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("rst_async", 4'b0000, 1'b0);
    #2;
    rst_n   = 1'b1;
    bus.req = 4'b1111;
    step();
    chk_out("rst_after", 4'b0001, 1'b0);
    bus.done = 1'b1;
    step();
    chk_out("rst_after_rel", 4'b0000, 1'b0);
    bus.done = 1'b0;
    step();
    chk_out("rst_after_next", 4'b0010, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
